// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of the RISC core.
// Issues reads to a 1-cycle-latency synchronous instruction memory, parks the
// returned words with their PC in a 2-entry queue, and hands the queue head to
// the core over a valid/ready handshake. A jump flushes the queue, cancels the
// read in flight and restarts fetching at the target address.
module instr_fetch #(
  parameter int                 A_SIZE   = 10,
  parameter int                 I_SIZE   = 16,
  parameter logic [A_SIZE-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [A_SIZE-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [I_SIZE-1:0] imem_data,
  output logic [I_SIZE-1:0] instr,
  output logic [A_SIZE-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [A_SIZE-1:0] jump_addr
);

  // Fetch side state: next address to request and the read issued last cycle.
  logic [A_SIZE-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [A_SIZE-1:0] r_inflight_pc;

  // Two-entry queue of {instruction, pc} with read/write pointers and fill count.
  logic [I_SIZE-1:0] r_q_instr [0:1];
  logic [A_SIZE-1:0] r_q_pc    [0:1];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_occ;
  logic              w_issue;
  logic [A_SIZE-1:0] w_next_pc;

  // Head of queue goes straight to the core; valid depends only on registers,
  // so instr_ready never loops back into instr_valid.
  assign instr_valid = (r_count != 2'd0);
  assign instr       = r_q_instr[r_rd_ptr];
  assign instr_pc    = r_q_pc[r_rd_ptr];

  // A transfer to the core empties the head slot at the coming edge.
  assign w_pop = instr_valid & instr_ready;

  // Returning memory data lands in the queue unless a jump discards it.
  assign w_push = r_inflight & ~jump;

  // Slots already spoken for: words held plus the word still on its way.
  // Never exceeds 2 because every read is issued against a free slot.
  assign w_occ = r_count + {1'b0, r_inflight};

  // Credit check: a new read is allowed if a slot is free now, or if the
  // last reserved slot is being released by a pop this very cycle.
  assign w_issue = (w_occ < 2'd2) | ((w_occ == 2'd2) & w_pop);

  // A jump overrides the normal fetch address in the same cycle.
  assign imem_addr = jump ? jump_addr : r_fetch_pc;
  assign imem_rd   = jump | w_issue;

  // Address following the one requested this cycle, wrapping at 2^A_SIZE.
  assign w_next_pc = imem_addr + {{(A_SIZE-1){1'b0}}, 1'b1};

  // Fetch PC and in-flight tracking; a jump always issues its target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (jump) begin
      r_fetch_pc    <= w_next_pc;
      r_inflight    <= 1'b1;
      r_inflight_pc <= jump_addr;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= w_next_pc;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  // Queue pointers and count; a jump flushes everything already queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (jump) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: capture the returning word with the PC it was fetched from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_instr[0] <= '0;
      r_q_instr[1] <= '0;
      r_q_pc[0]    <= '0;
      r_q_pc[1]    <= '0;
    end else if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_data;
      r_q_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run scored against a stream-level model of the fetch/queue behaviour.
module tb_instr_fetch;

  localparam int A = 10;
  localparam int I = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic         jump;
  logic [A-1:0] jaddr;
  logic [A-1:0] imem_addr;
  logic         imem_rd;
  logic [I-1:0] imem_data;
  logic [I-1:0] instr;
  logic [A-1:0] instr_pc;
  logic         instr_valid;

  logic         wr_ready;
  logic         wr_jump;
  logic [A-1:0] wr_jaddr;
  logic [A-1:0] wr_imem_addr;
  logic         wr_imem_rd;
  logic [I-1:0] wr_imem_data;
  logic [I-1:0] wr_instr;
  logic [A-1:0] wr_instr_pc;
  logic         wr_instr_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory contents: word k holds 16'h2800 + k.
  function automatic logic [I-1:0] mem_word(input logic [A-1:0] a);
    return 16'h2800 + {6'b0, a};
  endfunction

  always @(posedge clk) if (imem_rd)    imem_data    <= mem_word(imem_addr);
  always @(posedge clk) if (wr_imem_rd) wr_imem_data <= mem_word(wr_imem_addr);

  instr_fetch #(.A_SIZE(A), .I_SIZE(I), .RESET_PC(10'h000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(ready), .jump(jump), .jump_addr(jaddr)
  );

  instr_fetch #(.A_SIZE(A), .I_SIZE(I), .RESET_PC(10'h3FE)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(wr_imem_addr), .imem_rd(wr_imem_rd),
    .imem_data(wr_imem_data), .instr(wr_instr), .instr_pc(wr_instr_pc),
    .instr_valid(wr_instr_valid), .instr_ready(wr_ready), .jump(wr_jump),
    .jump_addr(wr_jaddr)
  );

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; jump = 1'b0; jaddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    n_checks++; if (instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr: got %0h want 0", instr); end
    n_checks++; if (instr_pc !== 10'h0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", instr_pc); end
    n_checks++; if (imem_addr !== 10'h0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
    rst = 1'b0; #1;
    n_checks++; if (imem_rd !== 1'b1) begin n_fail++; $display("FAIL reset_rd_release: got %0b want 1", imem_rd); end
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL latency_edge1: got %0b want 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, instr_valid); end
      n_checks++; if (instr_pc !== 10'(i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0h want %0h", i, instr_pc, i); end
      n_checks++; if (instr !== mem_word(10'(i))) begin n_fail++; $display("FAIL stream_instr[%0d]: got %0h want %0h", i, instr, mem_word(10'(i))); end
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    while ((instr_pc !== 10'd3 || instr_valid !== 1'b1) && guard <= 20) begin
      @(negedge clk); guard++;
    end
    n_checks++; if (guard > 20) begin n_fail++; $display("FAIL bp_reach_pc3: got pc %0h want 3 within 20 cycles", instr_pc); end
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", i, instr_valid); end
      n_checks++; if (instr_pc !== 10'd3) begin n_fail++; $display("FAIL bp_hold_pc[%0d]: got %0h want 3", i, instr_pc); end
      n_checks++; if (instr !== 16'h2803) begin n_fail++; $display("FAIL bp_hold_instr[%0d]: got %0h want 2803", i, instr); end
      if (i >= 1) begin
        n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_rd_stall[%0d]: got %0b want 0", i, imem_rd); end
      end
      @(negedge clk);
    end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid[%0d]: got %0b want 1", i, instr_valid); end
      n_checks++; if (instr_pc !== 10'(3 + i)) begin n_fail++; $display("FAIL bp_release_pc[%0d]: got %0h want %0h", i, instr_pc, 3 + i); end
      n_checks++; if (instr !== mem_word(10'(3 + i))) begin n_fail++; $display("FAIL bp_release_instr[%0d]: got %0h want %0h", i, instr, mem_word(10'(3 + i))); end
      @(negedge clk);
    end
  endtask

  task automatic test_jump_full();
    ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL full_stall_rd: got %0b want 0", imem_rd); end
    jump = 1'b1; jaddr = 10'd100; #1;
    n_checks++; if (imem_addr !== 10'd100) begin n_fail++; $display("FAIL jump_addr_out: got %0h want 64", imem_addr); end
    n_checks++; if (imem_rd !== 1'b1) begin n_fail++; $display("FAIL jump_rd: got %0b want 1", imem_rd); end
    @(negedge clk);
    jump = 1'b0; ready = 1'b1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jump_bubble: got %0b want 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL jump_valid[%0d]: got %0b want 1", i, instr_valid); end
      n_checks++; if (instr_pc !== 10'(100 + i)) begin n_fail++; $display("FAIL jump_pc[%0d]: got %0h want %0h", i, instr_pc, 100 + i); end
      n_checks++; if (instr !== mem_word(10'(100 + i))) begin n_fail++; $display("FAIL jump_instr[%0d]: got %0h want %0h", i, instr, mem_word(10'(100 + i))); end
    end
  endtask

  task automatic test_wrap();
    logic [A-1:0] wexp [4];
    int got = 0;
    int first = -1;
    wexp[0] = 10'h3FE; wexp[1] = 10'h3FF; wexp[2] = 10'h000; wexp[3] = 10'h001;
    rst = 1'b1; ready = 1'b1; jump = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 12 && got < 4; n++) begin
      @(negedge clk);
      if (wr_instr_valid === 1'b1) begin
        if (first < 0) first = n;
        n_checks++; if (wr_instr_pc !== wexp[got]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %0h want %0h", got, wr_instr_pc, wexp[got]); end
        n_checks++; if (wr_instr !== mem_word(wexp[got])) begin n_fail++; $display("FAIL wrap_instr[%0d]: got %0h want %0h", got, wr_instr, mem_word(wexp[got])); end
        got++;
      end
    end
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", got); end
    n_checks++; if (first != 2) begin n_fail++; $display("FAIL wrap_latency: got %0d want 2", first); end
  endtask

  task automatic test_reset_midop();
    ready = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %0b want 1", instr_valid); end
    rst = 1'b1; #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b want 0", instr_valid); end
    n_checks++; if (instr !== 16'h0) begin n_fail++; $display("FAIL midrst_instr: got %0h want 0", instr); end
    n_checks++; if (instr_pc !== 10'h0) begin n_fail++; $display("FAIL midrst_pc: got %0h want 0", instr_pc); end
    @(negedge clk);
    ready = 1'b1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_latency: got %0b want 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_valid_after[%0d]: got %0b want 1", i, instr_valid); end
      n_checks++; if (instr_pc !== 10'(i)) begin n_fail++; $display("FAIL midrst_pc_after[%0d]: got %0h want %0h", i, instr_pc, i); end
      n_checks++; if (instr !== mem_word(10'(i))) begin n_fail++; $display("FAIL midrst_instr_after[%0d]: got %0h want %0h", i, instr, mem_word(10'(i))); end
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    @(negedge clk);
    jump = 1'b1; jaddr = 10'd50;
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble1: got %0b want 0", instr_valid); end
    jaddr = 10'd200; #1;
    n_checks++; if (imem_addr !== 10'd200) begin n_fail++; $display("FAIL b2b_addr2: got %0h want c8", imem_addr); end
    @(negedge clk);
    jump = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble2: got %0b want 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0b want 1", i, instr_valid); end
      n_checks++; if (instr_pc !== 10'(200 + i)) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %0h want %0h", i, instr_pc, 200 + i); end
      n_checks++; if (instr !== mem_word(10'(200 + i))) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %0h want %0h", i, instr, mem_word(10'(200 + i))); end
    end
  endtask

  // Model: the core must see an unbroken run of PCs from the last jump target,
  // each paired with its memory word, valid one edge after the bubble, and a
  // stalled head held unchanged.
  task automatic test_random();
    logic [A-1:0] exp_pc;
    logic [A-1:0] hold_pc = '0;
    logic [I-1:0] hold_d = '0;
    logic         hold = 1'b0;
    logic         v;
    logic [A-1:0] p;
    logic [I-1:0] d;
    int           k;
    @(negedge clk);
    jump = 1'b1; jaddr = 10'($urandom); ready = 1'b1;
    exp_pc = jaddr; k = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (k < 10) k++;
      v = instr_valid; p = instr_pc; d = instr;
      if (k == 1) begin
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %0b want 0", c, v); end
      end else begin
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want 1", c, v); end
      end
      if (v === 1'b1) begin
        n_checks++; if (p !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %0h want %0h", c, p, exp_pc); end
        n_checks++; if (d !== mem_word(p)) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %0h want %0h", c, d, mem_word(p)); end
      end
      if (hold) begin
        n_checks++; if (v !== 1'b1 || p !== hold_pc || d !== hold_d) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %0b/%0h/%0h want 1/%0h/%0h", c, v, p, d, hold_pc, hold_d); end
      end
      jump  = ($urandom_range(0, 99) < 6);
      jaddr = 10'($urandom);
      ready = ($urandom_range(0, 99) < 65);
      #1;
      if (jump) begin
        n_checks++; if (imem_addr !== jaddr || imem_rd !== 1'b1) begin n_fail++; $display("FAIL rnd_jump_req[%0d]: got %0h/%0b want %0h/1", c, imem_addr, imem_rd, jaddr); end
        exp_pc = jaddr; k = 0; hold = 1'b0;
      end else begin
        if (v && ready) exp_pc = exp_pc + 10'd1;
        hold = v && !ready; hold_pc = p; hold_d = d;
      end
    end
    @(negedge clk);
    jump = 1'b0; ready = 1'b1;
  endtask

  initial begin
    wr_ready = 1'b1; wr_jump = 1'b0; wr_jaddr = '0;
    rst = 1'b1; ready = 1'b1; jump = 1'b0; jaddr = '0;
    test_reset();
    test_backpressure();
    test_jump_full();
    test_wrap();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
